id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage that registers decoded operands and controls, and drives the ALU operand inputs and ALU control-unit inputs (alu_op, func3, func7).
- Contains the forwarding muxes (MEM and WB results to ALU operands) and load-use hazard detection, which stalls decode and inserts a bubble.
- Sits between the decode/register-file stage and the execute ALU plus the EX/MEM register.

---
 rtl/id_ex_stage.sv | 208 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage -- decode-to-execute pipeline register with operand forwarding
// and load-use hazard detection.
//
// Purpose:
//   Latches the decoded instruction (operands, immediate, ALU controls and
//   memory/writeback enables) into EX.
//   Drives the ALU operands after MEM/WB forwarding and immediate selection.
//   Raises stall_id when the instruction in decode needs the result of a load
//   that is currently in EX. In that case a bubble is inserted into EX.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   flush                kill the instruction entering EX (redirect)
//   id_*                 decoded instruction presented by the decode stage
//   mem_rd/_reg_write/_result   destination and result in EX/MEM
//   wb_rd/_reg_write/_result    destination and result in MEM/WB
//   stall_id             hold PC and IF/ID this cycle
//   ex_*                 EX-stage fields; ex_a/ex_b are ALU operands,
//                        ex_store_data is the forwarded rs2 value
//   perf_stalls, perf_flushes   event counters (only with ID_EX_PERF_EN)
//
// Optional feature macro: ID_EX_PERF_EN adds the two 32-bit event counters.

module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_func3,
    input  logic            id_func7,
    input  logic            id_alu_src,
    input  logic            id_uses_rs2,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RAW-1:0]  wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [RAW-1:0]  ex_rd,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [1:0]      ex_alu_op,
    output logic [2:0]      ex_func3,
    output logic            ex_func7,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     perf_stalls,
    output logic [31:0]     perf_flushes
`endif
);

    // Latched EX-stage state
    logic            ex_valid_reg;
    logic [XLEN-1:0] ex_pc_reg;
    logic [RAW-1:0]  ex_rs1_reg;
    logic [RAW-1:0]  ex_rs2_reg;
    logic [RAW-1:0]  ex_rd_reg;
    logic [XLEN-1:0] ex_rs1_data_reg;
    logic [XLEN-1:0] ex_rs2_data_reg;
    logic [XLEN-1:0] ex_imm_reg;
    logic [1:0]      ex_alu_op_reg;
    logic [2:0]      ex_func3_reg;
    logic            ex_func7_reg;
    logic            ex_alu_src_reg;
    logic            ex_mem_read_reg;
    logic            ex_mem_write_reg;
    logic            ex_reg_write_reg;

    // Per-source-operand views so that rs1 and rs2 share one generate body
    logic [RAW-1:0]  id_rs_addr  [2];
    logic [XLEN-1:0] id_rs_rdata [2];
    logic [RAW-1:0]  ex_rs_addr  [2];
    logic [XLEN-1:0] ex_rs_data  [2];
    logic [XLEN-1:0] wt_data     [2];
    logic [XLEN-1:0] fwd_data    [2];

    assign id_rs_addr[0]  = id_rs1;
    assign id_rs_addr[1]  = id_rs2;
    assign id_rs_rdata[0] = id_rs1_data;
    assign id_rs_rdata[1] = id_rs2_data;
    assign ex_rs_addr[0]  = ex_rs1_reg;
    assign ex_rs_addr[1]  = ex_rs2_reg;
    assign ex_rs_data[0]  = ex_rs1_data_reg;
    assign ex_rs_data[1]  = ex_rs2_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rs
            logic wb_hit_id;
            logic mem_hit_ex;
            logic wb_hit_ex;

            // Write-through: the register file is written in the same
            // cycle it is read, so a WB result to this register must be
            // taken instead of the stale read data.
            assign wb_hit_id  = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs_addr[gi]);
            assign wt_data[gi] = wb_hit_id ? wb_result : id_rs_rdata[gi];

            // Forwarding on the latched operand. MEM is younger than WB,
            // so MEM wins. x0 is never forwarded.
            assign mem_hit_ex = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs_addr[gi]);
            assign wb_hit_ex  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs_addr[gi]);
            assign fwd_data[gi] = mem_hit_ex ? mem_result :
                                  wb_hit_ex  ? wb_result  : ex_rs_data[gi];
        end
    endgenerate

    // Load-use: the load in EX only has its data in MEM, too late for the
    // dependent instruction to enter EX next cycle.
    assign stall_id = id_valid & ex_valid_reg & ex_mem_read_reg & (ex_rd_reg != '0) &
                      ((ex_rd_reg == id_rs1) | (id_uses_rs2 & (ex_rd_reg == id_rs2)));

    logic insert_bubble;
    assign insert_bubble = flush | stall_id;

    // Bubbles clear every field, not just the enables. This gives a defined
    // harmless add (op 00, operands 0) and a zero destination.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || insert_bubble) begin
            ex_valid_reg     <= 1'b0;
            ex_pc_reg        <= '0;
            ex_rs1_reg       <= '0;
            ex_rs2_reg       <= '0;
            ex_rd_reg        <= '0;
            ex_rs1_data_reg  <= '0;
            ex_rs2_data_reg  <= '0;
            ex_imm_reg       <= '0;
            ex_alu_op_reg    <= '0;
            ex_func3_reg     <= '0;
            ex_func7_reg     <= 1'b0;
            ex_alu_src_reg   <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            ex_mem_write_reg <= 1'b0;
            ex_reg_write_reg <= 1'b0;
        end else begin
            ex_valid_reg     <= id_valid;
            ex_pc_reg        <= id_pc;
            ex_rs1_reg       <= id_rs1;
            ex_rs2_reg       <= id_rs2;
            ex_rd_reg        <= id_rd;
            ex_rs1_data_reg  <= wt_data[0];
            ex_rs2_data_reg  <= wt_data[1];
            ex_imm_reg       <= id_imm;
            ex_alu_op_reg    <= id_alu_op;
            ex_func3_reg     <= id_func3;
            ex_func7_reg     <= id_func7;
            ex_alu_src_reg   <= id_alu_src;
            ex_mem_read_reg  <= id_mem_read  & id_valid;
            ex_mem_write_reg <= id_mem_write & id_valid;
            ex_reg_write_reg <= id_reg_write & id_valid;
        end
    end

    assign ex_valid      = ex_valid_reg;
    assign ex_pc         = ex_pc_reg;
    assign ex_rd         = ex_rd_reg;
    assign ex_a          = fwd_data[0];
    assign ex_b          = ex_alu_src_reg ? ex_imm_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ex_alu_op     = ex_alu_op_reg;
    assign ex_func3      = ex_func3_reg;
    assign ex_func7      = ex_func7_reg;
    assign ex_mem_read   = ex_mem_read_reg;
    assign ex_mem_write  = ex_mem_write_reg;
    assign ex_reg_write  = ex_reg_write_reg;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stalls_reg;
    logic [31:0] perf_flushes_reg;

    // A flush that coincides with a stall counts as a flush only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stalls_reg  <= '0;
            perf_flushes_reg <= '0;
        end else if (flush) begin
            perf_flushes_reg <= perf_flushes_reg + 32'd1;
        end else if (stall_id) begin
            perf_stalls_reg  <= perf_stalls_reg + 32'd1;
        end
    end

    assign perf_stalls  = perf_stalls_reg;
    assign perf_flushes = perf_flushes_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. It keeps a behavioural model of the
// instruction held in EX. Expected outputs are derived from that model and
// the current MEM/WB inputs, using the forwarding and hazard rules.
// Directed scenarios pin the model to hand-computed values.
// Randomized traffic then exercises hazards, flushes and forwarding together.

module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RAW-1:0]  id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [1:0]      id_alu_op;
    logic [2:0]      id_func3;
    logic            id_func7, id_alu_src, id_uses_rs2;
    logic            id_mem_read, id_mem_write, id_reg_write;
    logic [RAW-1:0]  mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [RAW-1:0]  wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;
    logic            stall_id, ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [RAW-1:0]  ex_rd;
    logic [XLEN-1:0] ex_a, ex_b, ex_store_data;
    logic [1:0]      ex_alu_op;
    logic [2:0]      ex_func3;
    logic            ex_func7, ex_mem_read, ex_mem_write, ex_reg_write;
`ifdef ID_EX_PERF_EN
    logic [31:0]     perf_stalls, perf_flushes;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_func3(id_func3), .id_func7(id_func7),
        .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_alu_op(ex_alu_op), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
`ifdef ID_EX_PERF_EN
        , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    // Model of the instruction sitting in EX
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RAW-1:0]  rs1, rs2, rd;
        logic [XLEN-1:0] v1, v2, imm;
        logic [1:0]      op;
        logic [2:0]      f3;
        logic            f7, src, mr, mw, rw;
    } ex_t;

    ex_t         m;
    logic [31:0] m_stalls, m_flushes;
    logic        last_stall;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [RAW-1:0] rs, input logic [XLEN-1:0] v);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
        return v;
    endfunction

    function automatic logic model_stall();
        return id_valid && m.valid && m.mr && m.rd != 0 &&
               (m.rd == id_rs1 || (id_uses_rs2 && m.rd == id_rs2));
    endfunction

    task automatic compare_model();
        logic s;
        s = model_stall();
        last_stall = s;
        chk("stall_id", {31'd0, stall_id}, {31'd0, s});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("ex_alu_op", {30'd0, ex_alu_op}, {30'd0, m.op});
        chk("ex_func3", {29'd0, ex_func3}, {29'd0, m.f3});
        chk("ex_func7", {31'd0, ex_func7}, {31'd0, m.f7});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
        chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
        if (m.valid) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            chk("ex_a", ex_a, fwd(m.rs1, m.v1));
            chk("ex_b", ex_b, m.src ? m.imm : fwd(m.rs2, m.v2));
            chk("ex_store_data", ex_store_data, fwd(m.rs2, m.v2));
        end
`ifdef ID_EX_PERF_EN
        chk("perf_stalls", perf_stalls, m_stalls);
        chk("perf_flushes", perf_flushes, m_flushes);
`endif
    endtask

    task automatic update_model();
        logic s;
        s = model_stall();
        if (flush) m_flushes = m_flushes + 1;
        else if (s) m_stalls = m_stalls + 1;
        if (flush || s) begin
            m = '0;
        end else begin
            m.valid = id_valid;
            m.pc    = id_pc;
            m.rs1   = id_rs1;
            m.rs2   = id_rs2;
            m.rd    = id_rd;
            m.v1    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
            m.v2    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;
            m.imm   = id_imm;
            m.op    = id_alu_op;
            m.f3    = id_func3;
            m.f7    = id_func7;
            m.src   = id_alu_src;
            m.mr    = id_mem_read & id_valid;
            m.mw    = id_mem_write & id_valid;
            m.rw    = id_reg_write & id_valid;
        end
    endtask

    // Entered and left at a falling edge; inputs are changed only there.
    task automatic cycle();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [1:0] op, input logic [2:0] f3,
                          input logic src, input logic uses2, input logic mr, input logic mw,
                          input logic rw);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
        id_func3 = f3; id_func7 = 1'b0; id_alu_src = src; id_uses_rs2 = uses2;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic quiet_mem_wb();
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    initial begin
        logic [31:0] f_before, s_before;
        m = '0; m_stalls = 0; m_flushes = 0; last_stall = 0;

        // Reset with every id_* input nonzero
        rstn = 0; flush = 0;
        set_id(32'h100, 5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'h7, 2'b10, 3'b101,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        id_func7 = 1'b1;
        mem_rd = 5'd30; mem_reg_write = 1; mem_result = 32'h1;
        wb_rd = 5'd31; wb_reg_write = 1; wb_result = 32'h2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_id", {31'd0, stall_id}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_ctrl", {24'd0, ex_alu_op, ex_func3, ex_func7, ex_mem_read, ex_mem_write},
            32'd0);
        chk("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        @(negedge clk);
        rstn = 1;
        cycle();
        #1;
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_ex_pc", ex_pc, 32'h100);

        // R-type add: 4 + 5
        quiet_mem_wb();
        set_id(32'h104, 5'd1, 5'd2, 5'd7, 32'd4, 32'd5, 32'd0, 2'b10, 3'b000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        #1;
        chk("rtype_ex_a", ex_a, 32'd4);
        chk("rtype_ex_b", ex_b, 32'd5);
        chk("rtype_ex_func3", {29'd0, ex_func3}, 32'd0);
        chk("rtype_ex_valid", {31'd0, ex_valid}, 32'd1);

        // Forwarding priority on ex_rs1 = x3
        set_id(32'h108, 5'd3, 5'd0, 5'd8, 32'h99, 32'd0, 32'd0, 2'b10, 3'b000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        mem_rd = 3; mem_reg_write = 1; mem_result = 32'h11;
        wb_rd = 3; wb_reg_write = 1; wb_result = 32'h22;
        #1 chk("fwd_mem_prio", ex_a, 32'h11);
        mem_reg_write = 0;
        #1 chk("fwd_wb", ex_a, 32'h22);
        mem_reg_write = 1; mem_rd = 0;
        #1 chk("fwd_mem_x0_wb", ex_a, 32'h22);
        wb_reg_write = 0;
        #1 chk("fwd_none", ex_a, 32'h99);
        id_valid = 0;
        cycle();

        // Load-use: lw x5 then add x6, x5, x1
        quiet_mem_wb();
        set_id(32'h200, 5'd1, 5'd0, 5'd5, 32'h40, 32'd0, 32'd8, 2'b00, 3'b010,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(32'h204, 5'd5, 5'd1, 5'd6, 32'd0, 32'd7, 32'd0, 2'b10, 3'b000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("lu_stall", {31'd0, stall_id}, 32'd1);
        cycle();
        #1;
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall_id}, 32'd0);
        cycle();
        wb_rd = 5; wb_reg_write = 1; wb_result = 32'hABC;
        #1;
        chk("lu_ex_a_wb", ex_a, 32'hABC);
        chk("lu_ex_b", ex_b, 32'd7);
        chk("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
        quiet_mem_wb();

        // I-type addi with rs2 field matching a load destination and mem_rd
        set_id(32'h300, 5'd1, 5'd0, 5'd9, 32'h0, 32'd0, 32'd0, 2'b00, 3'b010,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(32'h304, 5'd1, 5'd9, 5'd10, 32'h10, 32'h3, 32'hFFFFFFFD, 2'b11, 3'b000,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 chk("itype_no_stall", {31'd0, stall_id}, 32'd0);
        cycle();
        mem_rd = 9; mem_reg_write = 1; mem_result = 32'h55;
        #1;
        chk("itype_ex_b", ex_b, 32'hFFFFFFFD);
        chk("itype_store_data", ex_store_data, 32'h55);
        quiet_mem_wb();

        // Flush together with a load-use stall
        set_id(32'h400, 5'd1, 5'd0, 5'd5, 32'h0, 32'd0, 32'd0, 2'b00, 3'b010,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(32'h404, 5'd5, 5'd1, 5'd6, 32'd0, 32'd0, 32'd0, 2'b10, 3'b000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        flush = 1;
        f_before = m_flushes; s_before = m_stalls;
        #1 chk("fs_stall", {31'd0, stall_id}, 32'd1);
        cycle();
        flush = 0;
        #1 chk("fs_ex_valid", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_EN
        chk("fs_perf_flushes", perf_flushes, f_before + 32'd1);
        chk("fs_perf_stalls", perf_stalls, s_before);
`endif

        // Asynchronous reset while a stall is pending
        set_id(32'h500, 5'd1, 5'd0, 5'd5, 32'h0, 32'd0, 32'd0, 2'b00, 3'b010,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(32'h504, 5'd0, 5'd5, 5'd6, 32'd0, 32'd0, 32'd0, 2'b10, 3'b000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("mr_stall_before", {31'd0, stall_id}, 32'd1);
        rstn = 0;
        #1;
        chk("mr_stall_after", {31'd0, stall_id}, 32'd0);
        chk("mr_ex_valid", {31'd0, ex_valid}, 32'd0);
        m = '0; m_stalls = 0; m_flushes = 0;
        #1 rstn = 1;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (!last_stall) begin
                id_valid     = ($urandom_range(0, 7) != 0);
                id_pc        = $urandom;
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_rd        = 5'($urandom_range(0, 7));
                id_rs1_data  = $urandom;
                id_rs2_data  = $urandom;
                id_imm       = $urandom;
                id_alu_op    = 2'($urandom);
                id_func3     = 3'($urandom);
                id_func7     = 1'($urandom);
                id_alu_src   = 1'($urandom);
                id_uses_rs2  = 1'($urandom);
                id_mem_read  = ($urandom_range(0, 2) == 0);
                id_mem_write = 1'($urandom);
                id_reg_write = 1'($urandom);
            end
            flush         = ($urandom_range(0, 9) == 0);
            mem_rd        = 5'($urandom_range(0, 7));
            mem_reg_write = 1'($urandom);
            mem_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_reg_write  = 1'($urandom);
            wb_result     = $urandom;
            cycle();
        end
        flush = 0;
        #1 compare_model();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
